// File: rtl/arith_pkg.sv
// Shared constants and result types for the small arithmetic leaf cells.
package arith_pkg;

   localparam int DEFAULT_WIDTH = 1;
   localparam int MAX_WIDTH     = 64;

   // Sized to the widest legal operand so any leaf can carry its result in it
   typedef struct packed {
      logic                 carry_out;
      logic                 overflow;
      logic [MAX_WIDTH-1:0] sum;
   } sum_result;

endpackage

// File: rtl/adder_unit_if.sv
// Operand/result bundle between a requester and an adder_unit.
interface adder_unit_if #(
   parameter int WIDTH = 1
);

   logic             in_valid;
   logic [WIDTH-1:0] addend_a;
   logic [WIDTH-1:0] addend_b;
   logic             carry_in;
   logic [WIDTH-1:0] sum_c;
   logic             carry_out;
   logic             overflow;
   logic             out_valid;

   modport master (
      output in_valid, addend_a, addend_b, carry_in,
      input  sum_c, carry_out, overflow, out_valid
   );

   modport slave (
      input  in_valid, addend_a, addend_b, carry_in,
      output sum_c, carry_out, overflow, out_valid
   );

endinterface

// File: rtl/adder_unit_full_adder_cell.sv
// One bit of the ripple-carry chain.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic half_sum;

   assign half_sum = a ^ b;
   assign s        = half_sum ^ cin;
   assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/adder_unit.sv
// Registered WIDTH-bit ripple adder with carry-out and signed-overflow flags.
module adder_unit
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic       clk,
   input logic       rst,
   adder_unit_if.slave bus
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_next;

   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             overflow_q;
   logic             valid_q;

   assign carry[0] = bus.carry_in;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
         .a    (bus.addend_a[i]),
         .b    (bus.addend_b[i]),
         .cin  (carry[i]),
         .s    (sum_next[i]),
         .cout (carry[i+1])
      );
   end

   // Result registers only load on accepted operands so idle-cycle garbage never reaches them
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q      <= '0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
      end else if (bus.in_valid) begin
         sum_q      <= sum_next;
         carry_q    <= carry[WIDTH];
         overflow_q <= carry[WIDTH] ^ carry[WIDTH-1];
         valid_q    <= 1'b1;
      end else begin
         valid_q    <= 1'b0;
      end
   end

   assign bus.sum_c     = sum_q;
   assign bus.carry_out = carry_q;
   assign bus.overflow  = overflow_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_adder_unit.sv
// Directed and random checks of adder_unit at WIDTH 1, 8 and 32.
module tb_adder_unit;
   import arith_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   adder_unit_if #(.WIDTH(1))  bus1  ();
   adder_unit_if #(.WIDTH(8))  bus8  ();
   adder_unit_if #(.WIDTH(32)) bus32 ();

   adder_unit #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
   adder_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
   adder_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input int w, input logic v, input logic [63:0] a,
                                 input logic [63:0] b, input logic c);
      case (w)
         1: begin
            bus1.in_valid = v; bus1.addend_a = a[0]; bus1.addend_b = b[0]; bus1.carry_in = c;
         end
         8: begin
            bus8.in_valid = v; bus8.addend_a = a[7:0]; bus8.addend_b = b[7:0]; bus8.carry_in = c;
         end
         default: begin
            bus32.in_valid = v; bus32.addend_a = a[31:0]; bus32.addend_b = b[31:0]; bus32.carry_in = c;
         end
      endcase
   endtask

   // Reference: wide integer add, overflow from operand/result sign bits
   function automatic sum_result ref_model(input int w, input logic [63:0] a,
                                           input logic [63:0] b, input logic c);
      logic [64:0] mask;
      logic [64:0] full;
      sum_result   r;
      mask        = (65'd1 << w) - 65'd1;
      full        = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {64'd0, c};
      r.sum       = full[63:0] & mask[63:0];
      r.carry_out = full[w];
      r.overflow  = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
      return r;
   endfunction

   task automatic check_dut(input string tag, input int w, input sum_result exp, input logic exp_valid);
      sum_result obs;
      logic      v;
      case (w)
         1: begin
            obs.sum = 64'(bus1.sum_c); obs.carry_out = bus1.carry_out;
            obs.overflow = bus1.overflow; v = bus1.out_valid;
         end
         8: begin
            obs.sum = 64'(bus8.sum_c); obs.carry_out = bus8.carry_out;
            obs.overflow = bus8.overflow; v = bus8.out_valid;
         end
         default: begin
            obs.sum = 64'(bus32.sum_c); obs.carry_out = bus32.carry_out;
            obs.overflow = bus32.overflow; v = bus32.out_valid;
         end
      endcase
      check_output({tag, ".sum"},       obs.sum,              exp.sum);
      check_output({tag, ".carry_out"}, 64'(obs.carry_out),   64'(exp.carry_out));
      check_output({tag, ".overflow"},  64'(obs.overflow),    64'(exp.overflow));
      check_output({tag, ".out_valid"}, 64'(v),               64'(exp_valid));
   endtask

   localparam sum_result ZERO = '{carry_out: 1'b0, overflow: 1'b0, sum: 64'h0};

   initial begin
      logic [3:0] exp1_sum;
      logic [3:0] exp1_co;
      logic [3:0] exp1_ov;
      logic [63:0] ra, rb;
      logic        rc;
      sum_result   exp;
      string       tag;
      int          widths[2];

      rst = 1'b1;
      apply_stimulus(1,  1'b0, 64'h0, 64'h0, 1'b0);
      apply_stimulus(8,  1'b0, 64'h0, 64'h0, 1'b0);
      apply_stimulus(32, 1'b0, 64'h0, 64'h0, 1'b0);
      tick();
      tick();
      check_dut("reset_w1",  1,  ZERO, 1'b0);
      check_dut("reset_w8",  8,  ZERO, 1'b0);
      check_dut("reset_w32", 32, ZERO, 1'b0);
      rst = 1'b0;

      // 1-bit truth table, back-to-back, index = {a,b}
      exp1_sum = 4'b0110;
      exp1_co  = 4'b1000;
      exp1_ov  = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab;
         ab = 2'(i);
         apply_stimulus(1, 1'b1, {63'd0, ab[1]}, {63'd0, ab[0]}, 1'b0);
         tick();
         exp.sum       = {63'd0, exp1_sum[i]};
         exp.carry_out = exp1_co[i];
         exp.overflow  = exp1_ov[i];
         $sformat(tag, "w1_ab%0d", i);
         check_dut(tag, 1, exp, 1'b1);
      end
      apply_stimulus(1, 1'b0, 64'h0, 64'h0, 1'b0);

      // 8-bit corner vectors with hand-computed results
      apply_stimulus(8, 1'b1, 64'hFF, 64'h01, 1'b0);
      tick();
      check_dut("w8_ff_01", 8, '{carry_out: 1'b1, overflow: 1'b0, sum: 64'h00}, 1'b1);
      apply_stimulus(8, 1'b1, 64'h7F, 64'h01, 1'b0);
      tick();
      check_dut("w8_7f_01", 8, '{carry_out: 1'b0, overflow: 1'b1, sum: 64'h80}, 1'b1);
      apply_stimulus(8, 1'b1, 64'h80, 64'h80, 1'b1);
      tick();
      check_dut("w8_80_80_c1", 8, '{carry_out: 1'b1, overflow: 1'b1, sum: 64'h01}, 1'b1);
      apply_stimulus(8, 1'b1, 64'h12, 64'h34, 1'b1);
      tick();
      check_dut("w8_12_34_c1", 8, '{carry_out: 1'b0, overflow: 1'b0, sum: 64'h47}, 1'b1);

      // Idle cycles with junk operands must leave the held result alone
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(8, 1'b0, {32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom));
         tick();
         $sformat(tag, "w8_gap%0d", i);
         check_dut(tag, 8, '{carry_out: 1'b0, overflow: 1'b0, sum: 64'h47}, 1'b0);
      end

      // Reset beats a valid operand in the same cycle
      apply_stimulus(8, 1'b1, 64'hFF, 64'hFF, 1'b0);
      rst = 1'b1;
      tick();
      check_dut("w8_rst_prio", 8, ZERO, 1'b0);
      rst = 1'b0;
      apply_stimulus(8, 1'b1, 64'h01, 64'h01, 1'b0);
      tick();
      check_dut("w8_after_rst", 8, '{carry_out: 1'b0, overflow: 1'b0, sum: 64'h02}, 1'b1);
      apply_stimulus(8, 1'b0, 64'h0, 64'h0, 1'b0);

      // Back-to-back random streams against the reference model
      widths[0] = 8;
      widths[1] = 32;
      foreach (widths[k]) begin
         for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom);
            apply_stimulus(widths[k], 1'b1, ra, rb, rc);
            tick();
            exp = ref_model(widths[k], ra, rb, rc);
            $sformat(tag, "rand_w%0d_%0d", widths[k], i);
            check_dut(tag, widths[k], exp, 1'b1);
         end
         apply_stimulus(widths[k], 1'b0, 64'h0, 64'h0, 1'b0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/adder_unit.md
# adder_unit

Registered WIDTH-bit binary adder with carry-in, carry-out and signed-overflow flag, built as a ripple chain of 1-bit full-adder cells. It is the basic arithmetic leaf used by datapath blocks that need a sum one clock after operands are presented. At the default WIDTH of 1 it implements the 1-bit truth table: 0+0=0, 0+1=1, 1+0=1, 1+1=0 with carry.

## Interface
Parameters:
- WIDTH, default 1: operand and sum width in bits; legal range 1–64.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands and carry_in are sampled this cycle.
- addend_a  input  WIDTH  first operand, unsigned or two's complement.
- addend_b  input  WIDTH  second operand.
- carry_in  input  1  carry into bit 0.
- sum_c  output  WIDTH  registered sum, modulo 2^WIDTH.
- carry_out  output  1  registered carry out of MSB (unsigned overflow).
- overflow  output  1  registered signed overflow (carry into MSB XOR carry out of MSB).
- out_valid  output  1  sum_c/carry_out/overflow hold a result from an accepted input.

## Operation
- Combinational path: ripple chain of WIDTH full-adder cells; cell i computes s_i = a_i ^ b_i ^ c_i, c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = carry_in.
- Full result is WIDTH+1 bits: {carry_out, sum_c} = addend_a + addend_b + carry_in.
- overflow = c_{WIDTH-1} ^ c_WIDTH; for WIDTH=1, c_0 is carry_in.
- in_valid=1: result, carry_out, overflow registered; out_valid set to 1.
- in_valid=0: sum_c, carry_out, overflow hold previous values; out_valid cleared to 0.
- No backpressure; one result per cycle sustained.
- X on addend inputs while in_valid=0 must not corrupt held outputs.

## Timing
- Latency: exactly 1 clock from in_valid sample to out_valid/result.
- Throughput: 1 operation per clock.
- Reset (rst=1 at rising edge): sum_c=0, carry_out=0, overflow=0, out_valid=0; rst has priority over in_valid.
- Reset mid-stream: operand sampled in the reset cycle is discarded; first valid result follows the first in_valid=1 cycle after rst deasserts.
- Outputs driven only by flops; no combinational input-to-output path.
- Wrap-around: all-ones + 1 → sum_c=0, carry_out=1.

## Structure
- Sub-module full_adder_cell (a, b, cin → s, cout), instantiated WIDTH times in a generate loop.
- Shared package (arith_pkg): default WIDTH constant, max WIDTH constant, and a sum_result struct {carry_out, overflow, sum} reused by other arithmetic leaves.
- Top adder_unit holds the carry chain wiring, flag logic and the output register stage.

## Test plan
- WIDTH=1, carry_in=0, in_valid=1, sweep (a,b) = (0,0),(0,1),(1,0),(1,1) → one cycle later sum_c = 0,1,1,0; carry_out = 0,0,0,1; out_valid=1 each cycle.
- WIDTH=8: 0xFF + 0x01, carry_in=0 → sum_c=0x00, carry_out=1, overflow=0; 0x7F + 0x01 → sum_c=0x80, carry_out=0, overflow=1.
- WIDTH=8: 0x80 + 0x80, carry_in=1 → sum_c=0x01, carry_out=1, overflow=1; 0x12 + 0x34, carry_in=1 → 0x47, flags 0.
- Valid gap: result 0x47 registered, then in_valid=0 with random operands for 3 cycles → sum_c stays 0x47, out_valid=0.
- Reset: assert rst with in_valid=1 and 0xFF+0xFF → next edge all outputs 0, out_valid=0; deassert, present 0x01+0x01 → 0x02 one cycle later.
- Random back-to-back stream (≥1000 ops, WIDTH=8 and 32) vs reference model (a+b+cin) delayed one cycle, checking sum_c, carry_out, overflow.
